// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word RAM plus KBSR/KBDR/DSR/DDR device registers,
// answering one MAR/MDR request at a time after a fixed number of wait cycles.
module lc3_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_ready,
  output logic [15:0] resp_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        kbsr_q;
  logic [7:0]  kb_char_q;
  logic        dsr_q;
  logic        disp_valid_q;
  logic [7:0]  disp_data_q;

  logic [15:0] mem [2**ADDR_W];

  logic        access;
  logic        acc_we;
  logic [15:0] acc_addr, acc_wdata;
  logic        is_io;
  logic [ADDR_W-1:0] ram_idx;
  logic        ram_write, kbdr_read, ddr_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            access  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the accept edge, before the latches load.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  assign is_io     = (acc_addr[15:9] == 7'h7F);
  assign ram_idx   = acc_addr[ADDR_W-1:0];
  assign ram_write = access && acc_we && !is_io;
  assign kbdr_read = access && !acc_we && (acc_addr == KBDR_ADDR);
  assign ddr_write = access && acc_we && (acc_addr == DDR_ADDR) && dsr_q;

  always_comb begin
    rdata_d = rdata_q;
    if (access && !acc_we) begin
      if (!is_io) begin
        rdata_d = mem[ram_idx];
      end else begin
        case (acc_addr)
          KBSR_ADDR: rdata_d = {kbsr_q, 15'b0};
          KBDR_ADDR: rdata_d = {8'h00, kb_char_q};
          DSR_ADDR:  rdata_d = {dsr_q, 15'b0};
          default:   rdata_d = 16'h0000;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_write) mem[ram_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
      kbsr_q       <= 1'b0;
      kb_char_q    <= 8'h00;
      dsr_q        <= 1'b1;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // A capture only happens while KBSR is clear, so it takes priority over a KBDR clear.
      if (kb_valid && !kbsr_q) begin
        kbsr_q    <= 1'b1;
        kb_char_q <= kb_data;
      end else if (kbdr_read) begin
        kbsr_q <= 1'b0;
      end
      if (ddr_write) begin
        disp_data_q  <= acc_wdata[7:0];
        disp_valid_q <= 1'b1;
        dsr_q        <= 1'b0;
      end else if (disp_valid_q && disp_ready) begin
        disp_valid_q <= 1'b0;
        dsr_q        <= 1'b1;
      end
    end
  end

  assign resp_ready = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign kb_ready   = ~kbsr_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: a WAIT_CYCLES=2 instance driven from a vector
// table and hand sequences, plus a WAIT_CYCLES=0 instance for back-to-back requests.
module tb_lc3_mem_responder;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] expRdata;
    logic        expKbReady;
    logic        expDispValid;
    logic [7:0]  expDispData;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;

  logic        req0_valid, req0_we;
  logic [15:0] req0_addr, req0_wdata;
  logic        resp0_ready;
  logic [15:0] resp0_rdata;
  logic        kb0_valid;
  logic [7:0]  kb0_data;
  logic        kb0_ready;
  logic        disp0_valid;
  logic [7:0]  disp0_data;
  logic        disp0_ready;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
  );

  lc3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req0_valid), .req_we(req0_we), .req_addr(req0_addr), .req_wdata(req0_wdata),
    .resp_ready(resp0_ready), .resp_rdata(resp0_rdata),
    .kb_valid(kb0_valid), .kb_data(kb0_data), .kb_ready(kb0_ready),
    .disp_valid(disp0_valid), .disp_data(disp0_data), .disp_ready(disp0_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle following DONE.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                               output logic [15:0] rdata, output logic kbr,
                               output logic dv, output logic [7:0] dd);
    int lat;
    bit seen;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_addr  = ~addr;
        req_wdata = ~wdata;
      end
      if (resp_ready) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    rdata = resp_rdata;
    kbr   = kb_ready;
    dv    = disp_valid;
    dd    = disp_data;
    req_valid = 1'b0;
    checkOutput($sformatf("latency_%h", addr), lat, 3);
    @(negedge clk);
    checkOutput($sformatf("pulse_end_%h", addr), {31'b0, resp_ready}, 0);
  endtask

  task automatic b2bPair(input logic we, input logic [15:0] a1, input logic [15:0] d1,
                         input logic [15:0] a2, input logic [15:0] d2,
                         input logic chk, input logic [15:0] e1, input logic [15:0] e2);
    req0_valid = 1'b1;
    req0_we    = we;
    req0_addr  = a1;
    req0_wdata = d1;
    @(negedge clk);
    checkOutput("b2b_first_ready", {31'b0, resp0_ready}, 1);
    if (chk) checkOutput("b2b_first_rdata", {16'b0, resp0_rdata}, {16'b0, e1});
    req0_addr  = a2;
    req0_wdata = d2;
    @(negedge clk);
    checkOutput("b2b_gap", {31'b0, resp0_ready}, 0);
    @(negedge clk);
    checkOutput("b2b_second_ready", {31'b0, resp0_ready}, 1);
    if (chk) checkOutput("b2b_second_rdata", {16'b0, resp0_rdata}, {16'b0, e2});
    req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_after", {31'b0, resp0_ready}, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_resp_ready"}, {31'b0, resp_ready}, 0);
    checkOutput({tag, "_resp_rdata"}, {16'b0, resp_rdata}, 0);
    checkOutput({tag, "_kb_ready"}, {31'b0, kb_ready}, 1);
    checkOutput({tag, "_disp_valid"}, {31'b0, disp_valid}, 0);
    checkOutput({tag, "_disp_data"}, {24'b0, disp_data}, 0);
  endtask

  initial begin
    vec_t vecs[9];
    logic [15:0] rd;
    logic kbr, dv;
    logic [7:0] dd;

    vecs[0] = '{1'b1, 16'h3001, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 16'h3001, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 16'hFE00, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 16'hFE00, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 16'h1005, 16'h1357, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1357, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 16'hFE08, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 16'hFE04, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 16'hFE06, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 8'h00};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    kb_valid = 1'b0; kb_data = 8'h0; disp_ready = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 16'h0; req0_wdata = 16'h0;
    kb0_valid = 1'b0; kb0_data = 8'h0; disp0_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, kbr, dv, dd);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d_rdata", i), {16'b0, rd}, {16'b0, vecs[i].expRdata});
      checkOutput($sformatf("vec%0d_kb_ready", i), {31'b0, kbr}, {31'b0, vecs[i].expKbReady});
      checkOutput($sformatf("vec%0d_disp_valid", i), {31'b0, dv}, {31'b0, vecs[i].expDispValid});
      checkOutput($sformatf("vec%0d_disp_data", i), {24'b0, dd}, {24'b0, vecs[i].expDispData});
    end

    // Keyboard path
    kb_valid = 1'b1; kb_data = 8'h41;
    @(negedge clk);
    kb_valid = 1'b0; kb_data = 8'h77;
    checkOutput("kb_full_ready", {31'b0, kb_ready}, 0);
    applyStimulus(1'b0, 16'hFE00, 16'h0, rd, kbr, dv, dd);
    checkOutput("kbsr_full", {16'b0, rd}, 32'h8000);
    checkOutput("kbsr_full_kb_ready", {31'b0, kbr}, 0);
    kb_valid = 1'b1; kb_data = 8'h99;
    @(negedge clk);
    kb_valid = 1'b0;
    applyStimulus(1'b0, 16'hFE02, 16'h0, rd, kbr, dv, dd);
    checkOutput("kbdr_data", {16'b0, rd}, 32'h0041);
    checkOutput("kbdr_kb_ready_next", {31'b0, kbr}, 1);
    applyStimulus(1'b0, 16'hFE00, 16'h0, rd, kbr, dv, dd);
    checkOutput("kbsr_empty", {16'b0, rd}, 32'h0000);

    // Display path
    applyStimulus(1'b1, 16'hFE06, 16'h1234, rd, kbr, dv, dd);
    checkOutput("ddr_disp_valid", {31'b0, dv}, 1);
    checkOutput("ddr_disp_data", {24'b0, dd}, 32'h34);
    applyStimulus(1'b0, 16'hFE04, 16'h0, rd, kbr, dv, dd);
    checkOutput("dsr_busy", {16'b0, rd}, 32'h0000);
    applyStimulus(1'b1, 16'hFE06, 16'h00AB, rd, kbr, dv, dd);
    checkOutput("ddr_drop_valid", {31'b0, dv}, 1);
    checkOutput("ddr_drop_data", {24'b0, dd}, 32'h34);
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
    checkOutput("disp_ack_valid", {31'b0, disp_valid}, 0);
    checkOutput("disp_ack_data", {24'b0, disp_data}, 32'h34);
    applyStimulus(1'b0, 16'hFE04, 16'h0, rd, kbr, dv, dd);
    checkOutput("dsr_ready", {16'b0, rd}, 32'h8000);

    // Zero-wait instance: back-to-back writes, then back-to-back reads
    b2bPair(1'b1, 16'h0020, 16'h1111, 16'h0021, 16'h2222, 1'b0, 16'h0, 16'h0);
    b2bPair(1'b0, 16'h0020, 16'h0, 16'h0021, 16'h0, 1'b1, 16'h1111, 16'h2222);

    // Reset in the middle of a write
    applyStimulus(1'b1, 16'h0010, 16'h1111, rd, kbr, dv, dd);
    kb_valid = 1'b1; kb_data = 8'h5A;
    @(negedge clk);
    kb_valid = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'hAAAA;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_reset_ready", {31'b0, resp_ready}, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkResetOutputs("mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_no_ready_%0d", i), {31'b0, resp_ready}, 0);
    end
    applyStimulus(1'b0, 16'h0010, 16'h0, rd, kbr, dv, dd);
    checkOutput("abort_no_commit", {16'b0, rd}, 32'h1111);
    applyStimulus(1'b0, 16'hFE02, 16'h0, rd, kbr, dv, dd);
    checkOutput("reset_kb_char", {16'b0, rd}, 32'h0000);
    applyStimulus(1'b0, 16'hFE04, 16'h0, rd, kbr, dv, dd);
    checkOutput("reset_dsr", {16'b0, rd}, 32'h8000);
    applyStimulus(1'b1, 16'h0010, 16'h5555, rd, kbr, dv, dd);
    applyStimulus(1'b0, 16'h0010, 16'h0, rd, kbr, dv, dd);
    checkOutput("post_reset_ram", {16'b0, rd}, 32'h5555);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
